cpu_bus_interconnect: RTL and testbench

//  Single-master to NUM_SLAVES bridge that consumes the CPU core wrapper's bus and routes each access to one

---
 rtl/cpu_bus_pkg.sv | 19 +
 rtl/cpu_bus_addr_decoder.sv | 27 ++
 rtl/cpu_bus_interconnect.sv | 155 +++++++++++++++
 tb/tb_cpu_bus_interconnect.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared widths, response codes and FSM encoding for the CPU bus interconnect.
package cpu_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_bus_addr_decoder.sv
// Base/mask address decoder; the lowest-index matching slave wins on overlap.
module cpu_bus_addr_decoder
  import cpu_bus_pkg::*;
#(
  parameter int                  N    = 4,
  parameter logic [N*ADDR_W-1:0] BASE = '0,
  parameter logic [N*ADDR_W-1:0] MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [N-1:0]      hit_o,
  output logic              any_hit_o
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    hit_o     = '0;
    any_hit_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_hit_o &&
          ((addr_i & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W])) begin
        hit_o[i]  = 1'b1;
        any_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_bus_interconnect.sv
// Single-master to NUM_SLAVES bridge: registered slave request, decode/timeout errors,
// and a one-cycle m_waitrequest-low response phase per completed access.
module cpu_bus_interconnect
  import cpu_bus_pkg::*;
#(
  parameter int                           NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_0000}},
  parameter int                           TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              m_addr,
  input  logic                           m_read,
  input  logic                           m_write,
  input  logic [DATA_W-1:0]              m_writedata,
  input  logic [STRB_W-1:0]              m_byteenable,
  output logic [DATA_W-1:0]              m_readdata,
  output logic [1:0]                     m_response,
  output logic                           m_waitrequest,
  output logic [NUM_SLAVES-1:0]          s_read,
  output logic [NUM_SLAVES-1:0]          s_write,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [DATA_W-1:0]              s_writedata,
  output logic [STRB_W-1:0]              s_byteenable,
  input  logic [NUM_SLAVES*DATA_W-1:0]   s_readdata,
  input  logic [NUM_SLAVES*2-1:0]        s_response,
  input  logic [NUM_SLAVES-1:0]          s_waitrequest
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_e                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   s_read_q, s_read_d, s_write_q, s_write_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_W-1:0]       be_q, be_d;
  logic [1:0]              resp_q, resp_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0]   hit, sel;
  logic                    any_hit, sel_wait;
  logic [DATA_W-1:0]       sel_rdata;
  logic [1:0]              sel_resp;

  cpu_bus_addr_decoder #(
    .N    (NUM_SLAVES),
    .BASE (SLAVE_BASE),
    .MASK (SLAVE_MASK)
  ) u_dec (
    .addr_i    (m_addr),
    .hit_o     (hit),
    .any_hit_o (any_hit)
  );

  // Only the slave currently strobed is observed; the others may drive anything.
  always_comb begin
    sel       = s_read_q | s_write_q;
    sel_rdata = '0;
    sel_resp  = '0;
    sel_wait  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel[i]) begin
        sel_rdata = sel_rdata | s_readdata[i*DATA_W +: DATA_W];
        sel_resp  = sel_resp  | s_response[i*2 +: 2];
        sel_wait  = sel_wait  | s_waitrequest[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    s_read_d  = s_read_q;
    s_write_d = s_write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m_read || m_write) begin
          addr_d  = m_addr;
          wdata_d = m_writedata;
          be_d    = m_byteenable;
          cnt_d   = '0;
          if (any_hit) begin
            s_write_d = m_write ? hit : '0;
            s_read_d  = m_write ? '0 : hit;
            state_d   = ST_ACCESS;
          end else begin
            resp_d  = RESP_DECERR;
            rdata_d = '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // Completion is tested first so it wins over a timeout in the same cycle.
        if (!sel_wait) begin
          rdata_d   = (|s_read_q) ? sel_rdata : '0;
          resp_d    = sel_resp;
          s_read_d  = '0;
          s_write_d = '0;
          state_d   = ST_RESP;
        end else if (cnt_d >= TO_LIM) begin
          rdata_d   = '0;
          resp_d    = RESP_SLVERR;
          s_read_d  = '0;
          s_write_d = '0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s_read_q  <= '0;
      s_write_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_read_q  <= s_read_d;
      s_write_q <= s_write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_waitrequest = (state_q != ST_RESP);
  assign m_readdata    = rdata_q;
  assign m_response    = resp_q;
  assign s_read        = s_read_q;
  assign s_write       = s_write_q;
  assign s_addr        = addr_q;
  assign s_writedata   = wdata_q;
  assign s_byteenable  = be_q;

endmodule

// File: tb/tb_cpu_bus_interconnect.sv
// Randomized plus directed bench for cpu_bus_interconnect against a cycle-count reference model.
module tb_cpu_bus_interconnect;

  localparam int NS = 4;
  localparam int TO = 8;

  // Slave 3 covers 0x0000_0000..0x0003_FFFF, overlapping slaves 0..2; only 0x0003_xxxx is its own.
  localparam logic [31:0] BASES [NS] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_0000};
  localparam logic [31:0] MASKS [NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFC_0000};
  localparam logic [NS*32-1:0] P_BASE = {BASES[3], BASES[2], BASES[1], BASES[0]};
  localparam logic [NS*32-1:0] P_MASK = {MASKS[3], MASKS[2], MASKS[1], MASKS[0]};

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       m_addr, m_writedata, m_readdata, s_addr, s_writedata;
  logic              m_read, m_write, m_waitrequest;
  logic [3:0]        m_byteenable, s_byteenable;
  logic [1:0]        m_response;
  logic [NS-1:0]     s_read, s_write, s_waitrequest;
  logic [NS*32-1:0]  s_readdata;
  logic [NS*2-1:0]   s_response;

  int n_checks = 0;
  int n_errors = 0;

  cpu_bus_interconnect #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     (P_BASE),
    .SLAVE_MASK     (P_MASK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m_addr        (m_addr),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_readdata    (m_readdata),
    .m_response    (m_response),
    .m_waitrequest (m_waitrequest),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_addr        (s_addr),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_readdata    (s_readdata),
    .s_response    (s_response),
    .s_waitrequest (s_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] addr);
    for (int i = 0; i < NS; i++)
      if ((addr & MASKS[i]) == BASES[i]) return i;
    return -1;
  endfunction

  // Selected slave holds fixed data and the given wait; all others drive noise.
  task automatic drive_slaves(input int sel, input logic [31:0] rd, input logic [1:0] rs, input logic wt);
    for (int i = 0; i < NS; i++) begin
      if (i == sel) begin
        s_readdata[i*32 +: 32] = rd;
        s_response[i*2 +: 2]   = rs;
        s_waitrequest[i]       = wt;
      end else begin
        s_readdata[i*32 +: 32] = $urandom;
        s_response[i*2 +: 2]   = 2'($urandom_range(0, 3));
        s_waitrequest[i]       = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wait"}, 32'(m_waitrequest), 32'd1);
    check({tag, "_srd"}, 32'(s_read), 32'd0);
    check({tag, "_swr"}, 32'(s_write), 32'd0);
  endtask

  // Called and returns at posedge+1. Model: strobe lasts min(waits+1, TO) cycles, ready the next cycle.
  task automatic do_access(input string tag, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] be, input int waits);
    int          sel, n_strobe;
    logic [31:0] sl_rdata, exp_rdata;
    logic [1:0]  sl_resp, exp_resp;
    logic [NS-1:0] exp_oh;
    bit          timed_out;
    sel       = decode(addr);
    sl_rdata  = $urandom;
    sl_resp   = 2'($urandom_range(0, 3));
    timed_out = (sel >= 0) && (waits + 1 > TO);
    n_strobe  = (sel < 0) ? 0 : (timed_out ? TO : waits + 1);
    exp_oh    = (sel < 0) ? '0 : NS'(1 << sel);
    if (sel < 0)        begin exp_resp = 2'b11; exp_rdata = 32'h0; end
    else if (timed_out) begin exp_resp = 2'b10; exp_rdata = 32'h0; end
    else                begin exp_resp = sl_resp; exp_rdata = wr ? 32'h0 : sl_rdata; end

    m_addr       = addr;
    m_write      = wr;
    m_read       = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    m_writedata  = wdata;
    m_byteenable = be;
    drive_slaves(sel, sl_rdata, sl_resp, 1'b1);
    @(posedge clk); #1;
    for (int c = 1; c <= n_strobe + 1; c++) begin
      drive_slaves(sel, sl_rdata, sl_resp, (c <= waits));
      @(negedge clk);
      if (c <= n_strobe) begin
        check({tag, "_wait_busy"}, 32'(m_waitrequest), 32'd1);
        check({tag, "_s_read"}, 32'(s_read), wr ? 32'd0 : 32'(exp_oh));
        check({tag, "_s_write"}, 32'(s_write), wr ? 32'(exp_oh) : 32'd0);
        check({tag, "_s_addr"}, s_addr, addr);
        check({tag, "_s_wdata"}, s_writedata, wdata);
        check({tag, "_s_be"}, 32'(s_byteenable), 32'(be));
      end else begin
        check({tag, "_ready"}, 32'(m_waitrequest), 32'd0);
        check({tag, "_strobe_off"}, 32'(s_read | s_write), 32'd0);
        check({tag, "_rdata"}, m_readdata, exp_rdata);
        check({tag, "_resp"}, 32'(m_response), 32'(exp_resp));
      end
      @(posedge clk); #1;
    end
    m_read  = 1'b0;
    m_write = 1'b0;
    m_addr  = $urandom;
    @(negedge clk);
    check_idle_outputs({tag, "_after"});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, d;
    int          r, w;
    rst = 1'b1;
    m_addr = '0; m_read = 1'b0; m_write = 1'b0; m_writedata = '0; m_byteenable = '0;
    s_readdata = '0; s_response = '0; s_waitrequest = '1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rdata", m_readdata, 32'h0);
    check("reset_resp", 32'(m_response), 32'd0);
    check("reset_saddr", s_addr, 32'h0);
    check("reset_swdata", s_writedata, 32'h0);
    check("reset_sbe", 32'(s_byteenable), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_access("t1_read_s1", 32'h0001_0004, 1'b0, 32'h0, 4'hF, 0);
    do_access("t2_write_s2", 32'h0002_0010, 1'b1, 32'h1234_5678, 4'b0011, 3);
    do_access("t3_unmapped", 32'hF000_0000, 1'b0, 32'h0, 4'hF, 0);
    do_access("t4_timeout", 32'h0000_0010, 1'b0, 32'h0, 4'hF, 1000);
    do_access("t4_next", 32'h0001_0020, 1'b1, 32'hCAFE_F00D, 4'b1100, 1);
    do_access("t5_overlap", 32'h0000_1000, 1'b0, 32'h0, 4'hF, 2);
    do_access("edge_complete_at_limit", 32'h0003_0040, 1'b0, 32'h0, 4'hF, TO - 1);

    // Reset during ACCESS: strobe drops on the next edge and no ready pulse follows.
    m_addr = 32'h0002_0100; m_read = 1'b1; m_write = 1'b0; m_writedata = 32'h5555_AAAA; m_byteenable = 4'hF;
    drive_slaves(2, 32'h1111_2222, 2'b00, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_pre_strobe", 32'(s_read), 32'd4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_read = 1'b0;
    @(negedge clk);
    check_idle_outputs("t6_reset");
    check("t6_reset_saddr", s_addr, 32'h0);
    check("t6_reset_rdata", m_readdata, 32'h0);
    check("t6_reset_resp", 32'(m_response), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("t6_no_pulse", 32'(m_waitrequest), 32'd1);
    end
    @(posedge clk); #1;
    do_access("t6_recover", 32'h0002_0104, 1'b0, 32'h0, 4'hF, 0);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 4);
      a = {16'h0, 16'($urandom)};
      case (r)
        1: a[31:16] = 16'h0001;
        2: a[31:16] = 16'h0002;
        3: a[31:16] = 16'h0003;
        4: a = $urandom;
        default: ;
      endcase
      d = $urandom;
      w = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 4);
      do_access("rand", a, 1'($urandom_range(0, 1)), d, 4'($urandom_range(0, 15)), w);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_idle_outputs("gap");
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
